// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared constants and types for the 51x51 multiplier / product assembly
//   datapath. Operands are split into three 17-bit digits. The partial-product
//   term interface carries four weighted terms, named by their width. Each
//   offset below is the bit position of the term's LSB in the final product.
// -----------------------------------------------------------------------------
package mult_pkg;

   localparam int DIGIT_W  = 17;
   localparam int T34_OFS  = 34;
   localparam int T51_OFS  = 25;
   localparam int T68_OFS  = 17;
   localparam int T102_OFS = 0;
   localparam int PROD_W   = 102;

   typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/product_assemble_51x51_csa_3to2.sv
// -----------------------------------------------------------------------------
// csa_3to2
//   Carry-save adder. It compresses three W-bit vectors into a sum vector and
//   a carry vector such that a + b + c == s + co (mod 2^W). The carry vector
//   is already shifted into position. The carry out of the MSB is dropped, so
//   the identity holds only modulo 2^W.
//
// Ports
//   a, b, c : input  [W-1:0]  operands
//   s       : output [W-1:0]  bitwise sum
//   co      : output [W-1:0]  majority carries, shifted left by one
// -----------------------------------------------------------------------------
module csa_3to2 #(
   parameter int W = 102
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] s,
   output logic [W-1:0] co
);

   logic [W-1:0] maj;

   assign s   = a ^ b ^ c;
   assign maj = (a & b) | (a & c) | (b & c);
   assign co  = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/product_assemble_51x51.sv
// -----------------------------------------------------------------------------
// product_assemble_51x51
//   Assembles the exact 102-bit product a*b from the four weighted partial
//   terms produced by the 51x51 digit multiplier. The block is a three-stage
//   elastic pipeline with valid/ready handshakes on both sides:
//     S1  align the terms, then compress 4 -> 2 with two CSA levels
//     S2  add the low SPLIT bits of sum and carry, and keep the carry-out
//     S3  add the upper halves plus that carry-out, giving the full product
//   Cutting the carry-propagate add at SPLIT keeps each adder at most
//   max(SPLIT, 102-SPLIT) bits long. SPLIT must be in the range 17..85.
//
// Ports
//   clk        : input          rising-edge clock
//   reset      : input          asynchronous active-high reset
//   in_valid   : input          term bundle valid
//   in_ready   : output         bundle is accepted this cycle
//   term_34w   : input  [33:0]  partial term, weight 2^34
//   term_51w   : input  [50:0]  partial term, weight 2^25
//   term_68w   : input  [67:0]  partial term, weight 2^17
//   term_102w  : input  [101:0] partial term, weight 2^0
//   out_valid  : output         product valid
//   out_ready  : input          downstream accepts the product
//   product    : output [101:0] t102 + (t68<<17) + (t51<<25) + (t34<<34)
// -----------------------------------------------------------------------------
module product_assemble_51x51
   import mult_pkg::*;
#(
   parameter int SPLIT  = 51,
   parameter int PROD_W = 102
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [33:0]       term_34w,
   input  logic [50:0]       term_51w,
   input  logic [67:0]       term_68w,
   input  logic [101:0]      term_102w,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product
);

   localparam int HI_W = PROD_W - SPLIT;

   // Pipeline control
   logic rdy_en;
   logic vld_p1, vld_p2, vld_p3;
   logic adv_p1, adv_p2, adv_p3;
   logic ld_p1, ld_p2, ld_p3;
   logic in_fire;

   // Stage data
   logic [PROD_W-1:0] sum_p1, carry_p1;
   logic [SPLIT-1:0]  lo_p2;
   logic              cy_p2;
   logic [HI_W-1:0]   sum_hi_p2, carry_hi_p2;
   logic [PROD_W-1:0] prod_p3;

   // Combinational datapath
   logic [PROD_W-1:0] ext_34, ext_51, ext_68, ext_102;
   logic [PROD_W-1:0] s_l1, c_l1, s_l2, c_l2;
   logic [SPLIT:0]    lo_sum;
   logic [HI_W-1:0]   hi_sum;

   // The readiness chain runs backwards from out_ready. A stage can load when
   // it is empty or when its current contents are leaving this cycle.
   assign adv_p3   = vld_p3 & out_ready;
   assign ld_p3    = ~vld_p3 | adv_p3;
   assign adv_p2   = vld_p2 & ld_p3;
   assign ld_p2    = ~vld_p2 | adv_p2;
   assign adv_p1   = vld_p1 & ld_p2;
   assign ld_p1    = ~vld_p1 | adv_p1;

   // rdy_en holds in_ready low for the first cycle after reset releases.
   assign in_ready = rdy_en & ld_p1;
   assign in_fire  = in_valid & in_ready;

   // Zero-extend each term and place it at its weight. Shifted-out bits can
   // only come from out-of-range terms, and the result is taken mod 2^102.
   assign ext_34  = {{(PROD_W-34){1'b0}}, term_34w} << T34_OFS;
   assign ext_51  = {{(PROD_W-51){1'b0}}, term_51w} << T51_OFS;
   assign ext_68  = {{(PROD_W-68){1'b0}}, term_68w} << T68_OFS;
   assign ext_102 = term_102w << T102_OFS;

   csa_3to2 #(.W(PROD_W)) u_csa_l1 (
      .a  (ext_102),
      .b  (ext_68),
      .c  (ext_51),
      .s  (s_l1),
      .co (c_l1)
   );

   csa_3to2 #(.W(PROD_W)) u_csa_l2 (
      .a  (s_l1),
      .b  (c_l1),
      .c  (ext_34),
      .s  (s_l2),
      .co (c_l2)
   );

   assign lo_sum = {1'b0, sum_p1[SPLIT-1:0]} + {1'b0, carry_p1[SPLIT-1:0]};
   assign hi_sum = sum_hi_p2 + carry_hi_p2 + {{(HI_W-1){1'b0}}, cy_p2};

   // Control registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_en <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (ld_p1) vld_p1 <= in_fire;
         if (ld_p2) vld_p2 <= vld_p1;
         if (ld_p3) vld_p3 <= vld_p2;
      end
   end

   // ---- S1: capture + 4:2 compression ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_p1   <= '0;
         carry_p1 <= '0;
      end else if (in_fire) begin
         sum_p1   <= s_l2;
         carry_p1 <= c_l2;
      end
   end

   // ---- S2: low-half carry-propagate add ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lo_p2       <= '0;
         cy_p2       <= 1'b0;
         sum_hi_p2   <= '0;
         carry_hi_p2 <= '0;
      end else if (adv_p1) begin
         lo_p2       <= lo_sum[SPLIT-1:0];
         cy_p2       <= lo_sum[SPLIT];
         sum_hi_p2   <= sum_p1[PROD_W-1:SPLIT];
         carry_hi_p2 <= carry_p1[PROD_W-1:SPLIT];
      end
   end

   // ---- S3: high-half add, final product ----
   // Loads only when a bundle arrives, so the product keeps its last value
   // while the pipe is empty or stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod_p3 <= '0;
      end else if (adv_p2) begin
         prod_p3 <= {hi_sum, lo_p2};
      end
   end

   assign out_valid = vld_p3;
   assign product   = prod_p3;

endmodule

// File: tb/tb_product_assemble_51x51.sv
module tb_product_assemble_51x51;

   typedef logic [101:0] p_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [33:0]  t34 = '0;
   logic [50:0]  t51 = '0;
   logic [67:0]  t68 = '0;
   logic [101:0] t102 = '0;

   logic         in_ready_a, out_valid_a;
   logic [101:0] product_a;
   logic         in_ready_b, out_valid_b;
   logic [101:0] product_b;

   always #5 clk = ~clk;

   product_assemble_51x51 #(.SPLIT(51), .PROD_W(102)) u_dut51 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
      .term_34w(t34), .term_51w(t51), .term_68w(t68), .term_102w(t102),
      .out_valid(out_valid_a), .out_ready(out_ready), .product(product_a)
   );

   product_assemble_51x51 #(.SPLIT(17), .PROD_W(102)) u_dut17 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
      .term_34w(t34), .term_51w(t51), .term_68w(t68), .term_102w(t102),
      .out_valid(out_valid_b), .out_ready(out_ready), .product(product_b)
   );

   // Reference model: a queue of expected products, with the cycle in which
   // each bundle was accepted.
   p_t  exp_q[$];
   int  acc_q[$];
   p_t  cur_exp = '0;
   int  cyc = 0;
   bit  lat_chk = 1'b0;
   int  n_checks = 0;
   int  n_err = 0;

   localparam logic [50:0] MAX51 = {51{1'b1}};

   task automatic chk(input string name, input p_t act, input p_t exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   function automatic p_t model_sum(input logic [33:0] a34, input logic [50:0] a51,
                                    input logic [67:0] a68, input logic [101:0] a102);
      p_t r;
      r = (p_t'(a34) << 34) + (p_t'(a51) << 25) + (p_t'(a68) << 17) + a102;
      return r;
   endfunction

   function automatic p_t golden(input logic [50:0] a, input logic [50:0] b);
      p_t x, y;
      x = p_t'(a);
      y = p_t'(b);
      return x * y;
   endfunction

   function automatic p_t pp(input logic [16:0] x, input logic [16:0] y);
      return p_t'(x) * p_t'(y);
   endfunction

   // Compare process: checks both instances against the model on every cycle.
   always @(negedge clk) begin
      if (!reset) begin
         chk("in_ready_agree", p_t'(in_ready_b), p_t'(in_ready_a));
         chk("out_valid_agree", p_t'(out_valid_b), p_t'(out_valid_a));
         if (out_valid_a) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", p_t'(out_valid_a), p_t'(1'b0));
            end else begin
               chk("product_split51", product_a, exp_q[0]);
               chk("product_split17", product_b, exp_q[0]);
               if (out_ready) begin
                  if (lat_chk) chk("latency", p_t'(cyc - acc_q[0]), p_t'(3));
                  void'(exp_q.pop_front());
                  void'(acc_q.pop_front());
               end
            end
         end else if (lat_chk && exp_q.size() > 0 && (cyc - acc_q[0]) >= 3) begin
            chk("out_valid_due", p_t'(out_valid_a), p_t'(1'b1));
         end
         if (in_valid && in_ready_a) begin
            exp_q.push_back(cur_exp);
            acc_q.push_back(cyc);
         end
      end
      cyc++;
   end

   task automatic set_terms(input logic [33:0] a34, input logic [50:0] a51,
                            input logic [67:0] a68, input logic [101:0] a102);
      t34      = a34;
      t51      = a51;
      t68      = a68;
      t102     = a102;
      cur_exp  = model_sum(a34, a51, a68, a102);
      in_valid = 1'b1;
   endtask

   // Digit decomposition of a*b into the four weighted terms.
   task automatic set_ab(input logic [50:0] a, input logic [50:0] b);
      logic [16:0] a0, a1, a2, b0, b1, b2;
      p_t x34, x51, x68, x102;
      a0 = a[16:0]; a1 = a[33:17]; a2 = a[50:34];
      b0 = b[16:0]; b1 = b[33:17]; b2 = b[50:34];
      x34  = pp(a1, b1);
      x51  = (pp(a0, b2) + pp(a2, b0)) << 9;
      x68  = pp(a0, b1) + pp(a1, b0);
      x102 = pp(a0, b0) + ((pp(a1, b2) + pp(a2, b1)) << 51) + (pp(a2, b2) << 68);
      set_terms(x34[33:0], x51[50:0], x68[67:0], x102);
      cur_exp = golden(a, b);
   endtask

   task automatic wait_accept();
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge clk);
         n++;
         ok = in_ready_a;
      end
      if (!ok) fail_now("accept_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 30) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() > 0) fail_now(name);
   endtask

   logic [50:0] tab_a [8];
   logic [50:0] tab_b [8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      tab_a = '{51'h7_1234_5678_9ABC, 51'h0_0000_0001_FFFF, 51'h5_5555_5555_5555, 51'h2_AAAA_AAAA_AAAA,
                51'h7_FFFF_FFFF_FFFF, 51'h0_0001_0000_0000, 51'h3_0F0F_F0F0_1234, 51'h6_DEAD_BEEF_CAFE};
      tab_b = '{51'h1_FEDC_BA98_7654, 51'h0_0000_0002_0001, 51'h7_FFFF_FFFF_FFFF, 51'h4_0000_0000_0001,
                51'h0_0000_0000_0002, 51'h0_0001_0000_0000, 51'h5_A5A5_5A5A_9876, 51'h1_0BAD_F00D_1357};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", p_t'(out_valid_a), p_t'(1'b0));
      chk("reset_product_a", product_a, p_t'(0));
      chk("reset_product_b", product_b, p_t'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("in_ready_after_reset", p_t'(in_ready_a), p_t'(1'b1));

      // Single-term placement, with the latency check enabled
      lat_chk = 1'b1;
      chk("model_pin_t102", model_sum(34'h0, 51'h0, 68'h0, 102'h1), 102'h1);
      set_terms(34'h0, 51'h0, 68'h0, 102'h1);
      wait_accept();
      idle(5);
      chk("empty_out_valid", p_t'(out_valid_a), p_t'(1'b0));
      chk("empty_product_holds", product_a, 102'h1);

      chk("model_pin_t34", model_sum(34'h1, 51'h0, 68'h0, 102'h0), 102'h4_0000_0000);
      set_terms(34'h1, 51'h0, 68'h0, 102'h0);
      wait_accept();
      idle(5);

      chk("model_pin_t51", model_sum(34'h0, 51'h1, 68'h0, 102'h0), 102'h200_0000);
      set_terms(34'h0, 51'h1, 68'h0, 102'h0);
      wait_accept();
      idle(5);

      // Largest operands: (2^51-1)^2 = 2^102 - 2^52 + 1
      chk("golden_pin_max", golden(MAX51, MAX51), {50'h3_FFFF_FFFF_FFFF, 52'h0_0000_0000_0001});
      set_ab(MAX51, MAX51);
      wait_accept();
      idle(5);

      // Carry crossing bit 51: (2^51-1) + 2^17
      chk("model_pin_carry51", model_sum(34'h0, 51'h0, 68'h1, 102'h7_FFFF_FFFF_FFFF),
          102'h8_0000_0001_FFFF);
      set_terms(34'h0, 51'h0, 68'h1, 102'h7_FFFF_FFFF_FFFF);
      wait_accept();
      // All-ones + 2^17 wraps mod 2^102 through both cut points
      chk("model_pin_wrap", model_sum(34'h0, 51'h0, 68'h1, {102{1'b1}}), 102'h1_FFFF);
      set_terms(34'h0, 51'h0, 68'h1, {102{1'b1}});
      wait_accept();
      // Out-of-range terms are still summed mod 2^102
      set_terms({34{1'b1}}, {51{1'b1}}, {68{1'b1}}, {102{1'b1}});
      wait_accept();
      idle(6);

      // Back-to-back bundles, out_ready held high
      for (int i = 0; i < 8; i++) begin
         set_ab(tab_a[i], tab_b[i]);
         wait_accept();
      end
      idle(6);
      chk("b2b_drained", p_t'(exp_q.size()), p_t'(0));

      // Stall with out_ready low while bundles are offered
      lat_chk   = 1'b0;
      out_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         set_ab(tab_a[k % 8], tab_b[(k + 3) % 8]);
         @(negedge clk);
         if (in_ready_a) k++;
         @(posedge clk);
         #1;
      end
      chk("stall_accepts", p_t'(k), p_t'(3));
      chk("stall_in_ready", p_t'(in_ready_a), p_t'(1'b0));
      chk("stall_out_valid", p_t'(out_valid_a), p_t'(1'b1));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain("stall_drain");
      idle(2);
      lat_chk = 1'b1;

      // Reset with two bundles in flight
      set_ab(tab_a[2], tab_b[5]);
      wait_accept();
      set_ab(tab_a[6], tab_b[1]);
      wait_accept();
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_out_valid", p_t'(out_valid_a), p_t'(1'b0));
      chk("async_reset_product_a", product_a, p_t'(0));
      chk("async_reset_product_b", product_b, p_t'(0));
      exp_q.delete();
      acc_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      set_ab(tab_a[7], tab_b[7]);
      wait_accept();
      idle(6);
      chk("post_reset_drained", p_t'(exp_q.size()), p_t'(0));
      chk("post_reset_product", product_a, golden(tab_a[7], tab_b[7]));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
